syscall_unit: RTL and testbench

SYSCALL_UNIT -- requirements
Module: syscall_unit

---
 rtl/syscall_pkg.sv | 20 ++
 rtl/syscall_if.sv | 10 +
 rtl/syscall_fifo.sv | 58 +++++
 rtl/syscall_unit.sv | 90 +++++++++
 tb/tb_syscall_unit.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/syscall_pkg.sv
// Shared definitions for the syscall unit: service numbers, output-record kinds
// and the control state encoding.
package syscall_pkg;
  localparam int SVC_PRINT_INT  = 1;
  localparam int SVC_HALT       = 10;
  localparam int SVC_PRINT_CHAR = 11;
  localparam int SVC_PRINT_HEX  = 34;

  typedef enum logic [1:0] {
    KIND_INT  = 2'd0,
    KIND_CHAR = 2'd1,
    KIND_HEX  = 2'd2
  } out_kind_e;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;
endpackage

// File: rtl/syscall_if.sv
// Output-record stream from the syscall unit to its consumer (console/host model).
interface syscall_if #(parameter int DATA_W = 32);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_kind;

  modport master (output out_valid, out_data, out_kind, input out_ready);
  modport slave  (input out_valid, out_data, out_kind, output out_ready);
endinterface

// File: rtl/syscall_fifo.sv
// Circular output queue; push is refused when full and pop when empty, both
// judged on registered occupancy so a same-cycle pop never frees a slot early.
module syscall_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/syscall_unit.sv
// Syscall execution unit: queues print services for the consumer, latches the
// hex display, and drains the queue before halting the CPU.
module syscall_unit
  import syscall_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int FIFO_DEPTH      = 8,
  parameter int HALT_CODE       = SVC_HALT,
  parameter int PRINT_INT_CODE  = SVC_PRINT_INT,
  parameter int PRINT_CHAR_CODE = SVC_PRINT_CHAR,
  parameter int PRINT_HEX_CODE  = SVC_PRINT_HEX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] v0,
  input  logic [DATA_W-1:0] a0,
  output logic              stall,
  output logic              halt,
  output logic [DATA_W-1:0] hex,
  output logic              bad_code,
  syscall_if.master         out_if
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e              state_q, state_d;
  logic                halt_q, halt_d, bad_q, bad_d;
  logic [DATA_W-1:0]   hex_q, hex_d;
  logic                is_int, is_char, is_hex, is_halt, is_print, run_en;
  logic                push, pop, full, empty;
  out_kind_e           kind;
  logic [DATA_W+1:0]   head;
  logic [CW-1:0]       fifo_count;

  always_comb begin
    is_int   = (v0 == DATA_W'(PRINT_INT_CODE));
    is_char  = (v0 == DATA_W'(PRINT_CHAR_CODE));
    is_hex   = (v0 == DATA_W'(PRINT_HEX_CODE));
    is_halt  = (v0 == DATA_W'(HALT_CODE));
    is_print = is_int | is_char | is_hex;
    run_en   = enable && (state_q == RUN);
    push     = run_en && is_print && !full;
    pop      = out_if.out_valid && out_if.out_ready;
    stall    = (state_q == DRAIN) || (run_en && is_print && full);
    kind     = is_hex ? KIND_HEX : (is_char ? KIND_CHAR : KIND_INT);

    state_d = state_q;
    case (state_q)
      RUN:     if (run_en && is_halt) state_d = DRAIN;
      DRAIN:   if (fifo_count == '0) state_d = HALTED;
      default: state_d = HALTED;
    endcase
    halt_d = (state_d == HALTED);
    hex_d  = (push && is_hex) ? a0 : hex_q;
    bad_d  = bad_q | (run_en && !is_print && !is_halt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      halt_q  <= 1'b0;
      hex_q   <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
      hex_q   <= hex_d;
      bad_q   <= bad_d;
    end
  end

  syscall_fifo #(.WIDTH(DATA_W + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   ({kind, a0}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign out_if.out_valid = ~empty;
  assign out_if.out_data  = head[DATA_W-1:0];
  assign out_if.out_kind  = head[DATA_W+1:DATA_W];
  assign halt             = halt_q;
  assign hex              = hex_q;
  assign bad_code         = bad_q;
endmodule

// File: tb/tb_syscall_unit.sv
// Directed bench for syscall_unit: hex latch, full-queue stall, drain-to-halt,
// bad code, reset during drain, and a randomised ordering run against a queue.
module tb_syscall_unit;
  import syscall_pkg::*;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [31:0] v0, a0;
  logic        stall, halt, bad_code;
  logic [31:0] hex;
  int          n_chk = 0, n_fail = 0;

  syscall_if #(.DATA_W(32)) oif ();

  syscall_unit #(.DATA_W(32), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .v0(v0), .a0(a0),
    .stall(stall), .halt(halt), .hex(hex), .bad_code(bad_code), .out_if(oif.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sys(input int code, input logic [31:0] arg);
    enable = 1'b1;
    v0     = code;
    a0     = arg;
  endtask

  logic [31:0] sb[$];
  logic        en_r, rdy_r, popped, pushed;
  logic [31:0] arg_r;

  initial begin
    reset = 1'b1; enable = 1'b0; v0 = '0; a0 = '0; oif.out_ready = 1'b0;
    tick(); tick();
    chk("rst_halt", halt, 0);
    chk("rst_stall", stall, 0);
    chk("rst_valid", oif.out_valid, 0);
    chk("rst_hex", hex, 0);
    chk("rst_bad", bad_code, 0);
    reset = 1'b0;
    tick();

    // PRINT_HEX: visible one cycle later with hex latched.
    sys(34, 32'hDEADBEEF); #1;
    chk("hex_nostall", stall, 0);
    chk("hex_pre_valid", oif.out_valid, 0);
    tick(); enable = 1'b0; #1;
    chk("hex_reg", hex, 32'hDEADBEEF);
    chk("hex_valid", oif.out_valid, 1);
    chk("hex_kind", oif.out_kind, 2);
    chk("hex_data", oif.out_data, 32'hDEADBEEF);
    oif.out_ready = 1'b1; tick(); oif.out_ready = 1'b0;
    chk("hex_popped", oif.out_valid, 0);

    // Fill with 8 chars, 9th must stall until a pop frees a slot.
    for (int i = 0; i < 8; i++) begin
      sys(11, 32'h41 + i); #1;
      chk("fill_stall", stall, 0);
      tick();
    end
    sys(11, 32'h100); #1;
    chk("full_stall0", stall, 1);
    tick();
    chk("full_stall1", stall, 1);
    chk("full_head", oif.out_data, 32'h41);
    chk("full_kind", oif.out_kind, 1);
    oif.out_ready = 1'b1; #1;
    chk("full_samecyc_pop", stall, 1);
    tick(); oif.out_ready = 1'b0; #1;
    chk("full_retry_ok", stall, 0);
    tick(); enable = 1'b0; #1;
    chk("full_count8", dut.fifo_count, 8);
    chk("full_head2", oif.out_data, 32'h42);

    oif.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("drain5_data", oif.out_data, 32'h42 + i);
      tick();
    end

    // HALT with 3 queued and consumer ready.
    sys(10, 0); #1;
    chk("halt_issue_stall", stall, 0);
    chk("halt_q0", oif.out_data, 32'h47);
    tick(); sys(1, 32'h55); #1;
    chk("drain_stall1", stall, 1);
    chk("drain_q1", oif.out_data, 32'h48);
    chk("drain_halt0", halt, 0);
    tick();
    chk("drain_stall2", stall, 1);
    chk("drain_q2", oif.out_data, 32'h100);
    tick();
    chk("drain_stall3", stall, 1);
    chk("drain_empty", oif.out_valid, 0);
    tick();
    chk("halted", halt, 1);
    chk("halted_stall", stall, 0);
    tick(); tick();
    chk("halted_ignore", oif.out_valid, 0);
    chk("halted_stay", halt, 1);
    enable = 1'b0; oif.out_ready = 1'b0;

    // Unknown service code.
    reset = 1'b1; tick(); reset = 1'b0; tick();
    sys(1, 32'd5); tick();
    sys(99, 32'd7); #1;
    chk("bad_nostall", stall, 0);
    tick(); enable = 1'b0; #1;
    chk("bad_set", bad_code, 1);
    chk("bad_count", dut.fifo_count, 1);
    chk("bad_head", oif.out_data, 5);
    tick(); tick();
    chk("bad_sticky", bad_code, 1);

    // Reset while draining with 4 queued.
    sys(34, 32'hABCD); tick();
    sys(11, 32'd3); tick();
    sys(1, 32'd4); tick();
    chk("pre_drain_count", dut.fifo_count, 4);
    chk("pre_drain_hex", hex, 32'hABCD);
    sys(10, 0); tick(); enable = 1'b0; #1;
    chk("in_drain_stall", stall, 1);
    reset = 1'b1; #1;
    chk("rstd_halt", halt, 0);
    chk("rstd_valid", oif.out_valid, 0);
    chk("rstd_hex", hex, 0);
    chk("rstd_state", dut.state_q, RUN);
    chk("rstd_bad", bad_code, 0);
    chk("rstd_stall", stall, 0);
    tick(); reset = 1'b0; tick();

    // Random consumer back-pressure across pointer wrap.
    for (int i = 0; i < 20; i++) begin
      en_r  = ($urandom_range(0, 3) != 0);
      rdy_r = 1'($urandom_range(0, 1));
      arg_r = 32'd200 + i;
      enable = en_r; v0 = 1; a0 = arg_r; oif.out_ready = rdy_r; #1;
      chk("rnd_stall", stall, (en_r && sb.size() == 8));
      chk("rnd_valid", oif.out_valid, (sb.size() != 0));
      popped = (sb.size() != 0) && rdy_r;
      pushed = en_r && (sb.size() < 8);
      if (popped) chk("rnd_order", oif.out_data, sb[0]);
      tick();
      if (popped) void'(sb.pop_front());
      if (pushed) sb.push_back(arg_r);
    end
    enable = 1'b0; oif.out_ready = 1'b1;
    for (int i = 0; i < 12 && sb.size() != 0; i++) begin
      chk("tail_order", oif.out_data, sb[0]);
      void'(sb.pop_front());
      tick();
    end
    chk("tail_sb_empty", sb.size(), 0);
    chk("tail_empty", oif.out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
